// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the I/D-cache line arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef logic owner_t;

  localparam owner_t PORT_I = 1'b0;
  localparam owner_t PORT_D = 1'b1;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

endpackage

// File: rtl/cache_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port that
// did not win last time is chosen.
module rr_pick2
  import cache_arb_pkg::*;
(
  input  logic   pend0,
  input  logic   pend1,
  input  owner_t last_grant,
  output logic   grant_valid,
  output owner_t grant_idx
);

  assign grant_valid = pend0 | pend1;
  assign grant_idx   = (pend0 & pend1) ? owner_t'(~last_grant) : owner_t'(pend1);

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single cacheline adaptor port between the I-cache (port 0) and
// the D-cache (port 1), one latched transaction at a time.
//
//   state   | meaning
//   IDLE    | no transaction; arbitrate pending ports
//   BUSY    | latched request held on the adaptor until mem_resp
//   RELEASE | dead cycle so the finished requester can drop its request
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_read,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LINE_W-1:0] req0_wdata,
  output logic [LINE_W-1:0] req0_rdata,
  output logic              req0_resp,
  input  logic              req1_read,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LINE_W-1:0] req1_wdata,
  output logic [LINE_W-1:0] req1_rdata,
  output logic              req1_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state, state_d;
  owner_t            owner, last_grant, grant_idx;
  logic              op_write, reset_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              pend0, pend1, grant_valid;
  logic              grant, done, active, rdata_en;

  assign pend0 = req0_read | req0_write;
  assign pend1 = req1_read | req1_write;

  rr_pick2 u_pick (
    .pend0       (pend0),
    .pend1       (pend1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d = state;
    grant   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          grant   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          done    = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      state      <= IDLE;
      owner      <= PORT_I;
      last_grant <= PORT_D;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_d;
      if (grant) begin
        owner      <= grant_idx;
        last_grant <= grant_idx;
        // read+write together is treated as a write
        op_write   <= (grant_idx == PORT_D) ? req1_write : req0_write;
        addr_q     <= (grant_idx == PORT_D) ? req1_addr  : req0_addr;
        wdata_q    <= (grant_idx == PORT_D) ? req1_wdata : req0_wdata;
      end
    end
  end

  // Gate with reset so a synchronous reset mid-BUSY is quiet immediately.
  assign active    = (state == BUSY) & ~reset;
  assign mem_read  = active & ~op_write;
  assign mem_write = active & op_write;
  assign mem_addr  = active ? addr_q  : '0;
  assign mem_wdata = active ? wdata_q : '0;

  assign req0_resp = done & ~reset & (owner == PORT_I);
  assign req1_resp = done & ~reset & (owner == PORT_D);

  assign rdata_en   = ~(reset | reset_q);
  assign req0_rdata = rdata_en ? mem_rdata : '0;
  assign req1_rdata = rdata_en ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: the bench plays both caches and the
// adaptor; expected transactions are queued as requests are raised.
module tb_cache_arbiter;
  import cache_arb_pkg::*;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_read, req0_write, req0_resp;
  logic [AW-1:0] req0_addr;
  logic [LW-1:0] req0_wdata, req0_rdata;
  logic          req1_read, req1_write, req1_resp;
  logic [AW-1:0] req1_addr;
  logic [LW-1:0] req1_wdata, req1_rdata;
  logic          mem_read, mem_write, mem_resp;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;

  typedef struct {
    logic          port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_read  (req0_read),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_rdata (req0_rdata),
    .req0_resp  (req0_resp),
    .req1_read  (req1_read),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_rdata (req1_rdata),
    .req1_resp  (req1_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  task automatic check_val(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [LW-1:0] d);
    if (p) begin
      req1_read = rd; req1_write = wr; req1_addr = a; req1_wdata = d;
    end else begin
      req0_read = rd; req0_write = wr; req0_addr = a; req0_wdata = d;
    end
  endtask

  task automatic request(input logic p, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [LW-1:0] d);
    exp_t e;
    drive(p, rd, wr, a, d);
    e.port = p; e.wr = wr; e.addr = a; e.wdata = d;
    sb.push_back(e);
  endtask

  task automatic set_payload(input logic p, input logic [AW-1:0] a, input logic [LW-1:0] d);
    if (p) begin req1_addr = a; req1_wdata = d; end
    else   begin req0_addr = a; req0_wdata = d; end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_strobes"}, {mem_read, mem_write}, 2'b00);
    check_val({tag, "_resps"}, {req0_resp, req1_resp}, 2'b00);
  endtask

  // Acts as the adaptor for the oldest queued transaction.
  task automatic serve(input int exp_delay, input int lat, input logic [LW-1:0] rd, input bit drop);
    exp_t          e;
    int            n;
    logic [AW-1:0] sa;
    logic [LW-1:0] sd;
    if (sb.size() == 0) begin
      check_val("sb_empty", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    n = 0;
    #1;
    while (!(mem_read || mem_write) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check_val("strobe_delay", LW'(n), LW'(exp_delay));
    check_val("mem_write", mem_write, e.wr);
    check_val("mem_read", mem_read, !e.wr);
    check_val("mem_addr", mem_addr, e.addr);
    check_val("mem_wdata", mem_wdata, e.wdata);
    sa = e.port ? req1_addr : req0_addr;
    sd = e.port ? req1_wdata : req0_wdata;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      set_payload(e.port, 32'h0000_3000, ~sd);
      #1;
      check_val("hold_strobe", {mem_read, mem_write}, {!e.wr, e.wr});
      check_val("hold_addr", mem_addr, e.addr);
      check_val("hold_wdata", mem_wdata, e.wdata);
      check_val("hold_resps", {req0_resp, req1_resp}, 2'b00);
    end
    @(negedge clk);
    set_payload(e.port, sa, sd);
    mem_resp  = 1'b1;
    mem_rdata = rd;
    #1;
    check_val("owner_resp", e.port ? req1_resp : req0_resp, 1'b1);
    check_val("other_resp", e.port ? req0_resp : req1_resp, 1'b0);
    check_val("owner_rdata", e.port ? req1_rdata : req0_rdata, rd);
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = {8{$urandom}};
    if (drop) drive(e.port, 1'b0, 1'b0, sa, sd);
    #1;
    check_quiet("release");
    check_val("release_addr", mem_addr, '0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    mem_resp = 1'b0;
    mem_rdata = '1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk); @(negedge clk); #1;
    check_quiet("in_reset");
    check_val("in_reset_rdata", req0_rdata | req1_rdata, '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_quiet("post_reset");
    check_val("post_reset_rdata", req0_rdata | req1_rdata, '0);
    check_val("post_reset_addr", mem_addr, '0);
    @(negedge clk);
  endtask

  initial begin
    logic [LW-1:0] pat_a5;
    logic [LW-1:0] rd1;
    reset = 1'b1;
    mem_resp = 1'b0;
    mem_rdata = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    pat_a5 = {32{8'hA5}};
    rd1    = {4{64'hDEAD_BEEF_0123_4567}};
    reset_dut();

    // simultaneous first requests after reset: port 0 wins the tie
    request(1'b0, 1'b1, 1'b0, 32'h0000_0100, '0);
    request(1'b1, 1'b1, 1'b0, 32'h0000_0200, '0);
    serve(1, 2, {8{32'h1111_0000}}, 1'b1);
    serve(2, 2, {8{32'h2222_0000}}, 1'b1);

    // port 0 read
    reset_dut();
    request(1'b0, 1'b1, 1'b0, 32'h0000_1000, '0);
    serve(1, 5, rd1, 1'b1);

    // port 1 write; payload scrambled during BUSY inside serve
    @(negedge clk);
    request(1'b1, 1'b0, 1'b1, 32'h0000_2040, pat_a5);
    serve(1, 4, {8{$urandom}}, 1'b1);

    // continuous contention: grants alternate 0,1,0,1 (last grant was 1)
    @(negedge clk);
    request(1'b0, 1'b1, 1'b0, 32'h0000_4000, '0);
    request(1'b1, 1'b0, 1'b1, 32'h0000_5000, {8{32'hCAFE_F00D}});
    sb.push_back(sb[0]);
    sb.push_back(sb[1]);
    serve(1, 3, {8{32'hA000_0001}}, 1'b0);
    for (int k = 0; k < 3; k++) serve(2, 2 + k, {8{$urandom}}, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);

    // spurious mem_resp in IDLE
    @(negedge clk); @(negedge clk);
    mem_resp = 1'b1;
    #1;
    check_quiet("spurious");
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    check_quiet("after_spurious");

    // reset mid-BUSY abandons the transaction silently
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_6000, '0);
    @(negedge clk); #1;
    check_val("pre_abort_read", mem_read, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    mem_resp = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check_quiet("abort_in_reset");
    @(negedge clk);
    reset = 1'b0;
    mem_resp = 1'b0;
    #1;
    check_quiet("abort_after_reset");
    @(negedge clk);
    request(1'b1, 1'b1, 1'b0, 32'h0000_7000, '0);
    serve(1, 3, {8{32'h7777_7777}}, 1'b1);

    // read+write together is a write
    @(negedge clk);
    request(1'b0, 1'b1, 1'b1, 32'h0000_8000, {8{32'h0BAD_CAFE}});
    serve(1, 2, '0, 1'b1);

    check_val("sb_drained", LW'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
